// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART receive path
package uart_pkg;

    localparam int UART_DATA_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver capture and host read signals of the receive byte buffer
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_ready;
    logic                   rd_en;
    logic                   ovf_clr;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   empty;
    logic                   full;
    logic                   almost_full;
    logic [ADDR_W:0]        count;
    logic                   overflow;

    modport master (
        output rx_data, rx_ready, rd_en, ovf_clr,
        input  rd_data, empty, full, almost_full, count, overflow
    );

    modport slave (
        input  rx_data, rx_ready, rd_en, ovf_clr,
        output rd_data, empty, full, almost_full, count, overflow
    );
endinterface

// File: rtl/uart_edge_det.sv
// rtl/uart_edge_det.sv - registered single-bit rising-edge detector for done flags
module uart_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte buffer behind the UART receiver
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = clog2(DEPTH),
    parameter int AFULL_THRESH = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_THRESH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   wr_stb, rd_stb, wr_ok, drop;
    logic                   empty_w, full_w;

    uart_edge_det u_wr_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.rx_ready),
        .rise_o (wr_stb)
    );

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign rd_stb  = bus.rd_en & ~empty_w;
    // A pop in the same cycle frees the slot, so a full buffer can still take the write.
    assign wr_ok   = wr_stb & (~full_w | rd_stb);
    assign drop    = wr_stb & full_w & ~rd_stb;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_stb) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_stb})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rd_data     = empty_w ? '0 : mem[rd_ptr_q];
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = (count_q >= AFULL_C);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule
